tx_frame_arbiter: RTL

- Shares the single TX FIFO write port between several response producers, e.g. ALU result, register-file read-back and error/status reporter.
- Grants one requester at a time in round-robin order and latches its payload.
- Serialises a 1- or 2-byte response into byte writes on the FIFO write interface, stalling on FIFO full.
- Sits in the REF clock domain between the command controller/datapath and the async FIFO feeding UART TX.

---
 rtl/tx_frame_arbiter_pkg.sv | 22 ++
 rtl/tx_frame_arbiter_rr_arbiter.sv | 35 +++
 rtl/tx_frame_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/tx_frame_arbiter_pkg.sv
// Shared definitions for the TX frame arbiter: FSM encoding, byte selects, clog2.
package tx_frame_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      SEND_LO = 2'b01,
      SEND_HI = 2'b10
   } state_t;

   // Byte lane indices within a payload word; low byte goes out first.
   localparam int BYTE_LO = 0;
   localparam int BYTE_HI = 1;

   // Ceiling log2, used to size index fields from a requester count.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/tx_frame_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_arbiter
   import tx_frame_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = 3,
   parameter int ID_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] ptr,
   output logic [NUM_REQ-1:0]  grant,
   output logic [ID_WIDTH-1:0] winner,
   output logic                any_req
);

   logic found;

   // Scan ptr+1, ptr+2, ... modulo NUM_REQ; the first hit wins.
   always_comb begin
      grant  = '0;
      winner = '0;
      found  = 1'b0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && (j == ((int'(ptr) + off) % NUM_REQ))) begin
               found    = 1'b1;
               winner   = ID_WIDTH'(j);
               grant[j] = 1'b1;
            end
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter that serialises 1- or 2-byte responses into the TX FIFO.
module tx_frame_arbiter
   import tx_frame_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int OUT_WIDTH  = 16,
   parameter int NUM_REQ    = 3,
   parameter int ID_WIDTH   = 2
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NUM_REQ-1:0]            REQ,
   input  logic [NUM_REQ*OUT_WIDTH-1:0]  REQ_DATA,
   input  logic [NUM_REQ-1:0]            REQ_TWO_BYTE,
   input  logic                          FIFO_FULL,
   output logic [NUM_REQ-1:0]            ACK,
   output logic [DATA_WIDTH-1:0]         TX_P_DATA,
   output logic                          TX_DATA_VALID,
   output logic [ID_WIDTH-1:0]           GRANT_ID,
   output logic                          BUSY
);

   state_t                state, next_state;
   logic [ID_WIDTH-1:0]   ptr, winner;
   logic [NUM_REQ-1:0]    grant;
   logic                  any_req, load;
   logic [OUT_WIDTH-1:0]  payload, sel_data;
   logic                  two_byte, sel_two;
   logic [DATA_WIDTH-1:0] last_byte, tx_byte;
   logic                  tx_valid;

   rr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_rr (
      .req     (REQ),
      .ptr     (ptr),
      .grant   (grant),
      .winner  (winner),
      .any_req (any_req)
   );

   // Pick the winner's payload slice and length flag.
   always_comb begin
      sel_data = '0;
      sel_two  = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (grant[j]) begin
            sel_data = REQ_DATA[j*OUT_WIDTH +: OUT_WIDTH];
            sel_two  = REQ_TWO_BYTE[j];
         end
      end
   end

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state and byte-write outputs; a write completes only when the FIFO has room.
   always_comb begin
      next_state = state;
      load       = 1'b0;
      tx_valid   = 1'b0;
      tx_byte    = last_byte;
      case (state)
         IDLE: begin
            if (any_req) begin
               load       = 1'b1;
               next_state = SEND_LO;
            end
         end
         SEND_LO: begin
            tx_byte  = payload[BYTE_LO*DATA_WIDTH +: DATA_WIDTH];
            tx_valid = !FIFO_FULL;
            if (tx_valid) next_state = two_byte ? SEND_HI : IDLE;
         end
         SEND_HI: begin
            tx_byte  = payload[BYTE_HI*DATA_WIDTH +: DATA_WIDTH];
            tx_valid = !FIFO_FULL;
            if (tx_valid) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Grant bookkeeping, payload latch and last-byte hold for the idle data bus.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ptr       <= ID_WIDTH'(NUM_REQ - 1);
         GRANT_ID  <= '0;
         ACK       <= '0;
         payload   <= '0;
         two_byte  <= 1'b0;
         last_byte <= '0;
      end else begin
         ACK       <= load ? grant : '0;
         last_byte <= tx_byte;
         if (load) begin
            ptr      <= winner;
            GRANT_ID <= winner;
            payload  <= sel_data;
            two_byte <= sel_two;
         end
      end
   end

   assign TX_P_DATA     = tx_byte;
   assign TX_DATA_VALID = tx_valid;
   assign BUSY          = (state != IDLE);

endmodule
